// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: 32 shift-add or restoring steps, then a FIX cycle.
// Define MULT_DIV_SIGNED_EN to make op 01 (MULT) and op 11 (DIV) signed.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isDiv_q, isDiv_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

`ifdef MULT_DIV_SIGNED_EN
    logic             negQ_q, negQ_d;
    logic             negR_q, negR_d;
    logic             divZero_q, divZero_d;
    logic             isSigned;
    logic [2*WIDTH-1:0] prodNeg;
`else
    logic             unusedOpSign;
    assign unusedOpSign = op[0];
`endif

    logic             accept;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] remSub;
    logic             remGe;
    logic [WIDTH-1:0] aMag, bMag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        isDiv_d = isDiv_q;
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        opB_d   = opB_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_DIV_SIGNED_EN
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        divZero_d = divZero_q;
        isSigned  = op[0];
        aMag      = (isSigned && a[WIDTH-1]) ? -a : a;
        bMag      = (isSigned && b[WIDTH-1]) ? -b : b;
        prodNeg   = -{accHi_q, accLo_q};
`else
        aMag = a;
        bMag = b;
`endif
        accept = start && ((state_q == IDLE) || (state_q == DONE));

        // Multiply keeps {accHi,accLo} as partial product over the shifting multiplier;
        // divide keeps accHi as partial remainder and accLo as dividend/quotient.
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
        remShift = {accHi_q, accLo_q[WIDTH-1]};
        remGe    = (remShift >= {1'b0, opB_q});
        remSub   = remShift[WIDTH-1:0] - opB_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = CALC;
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (isDiv_q) begin
                    accHi_d = remGe ? remSub : remShift[WIDTH-1:0];
                    accLo_d = {accLo_q[WIDTH-2:0], remGe};
                end else begin
                    accHi_d = mulSum[WIDTH:1];
                    accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
`ifdef MULT_DIV_SIGNED_EN
                // With a zero divisor the remainder already holds |a|, so the
                // dividend-sign fix restores raw a; only the quotient is forced.
                if (isDiv_q) begin
                    lo_d = divZero_q ? '1 : (negQ_q ? -accLo_q : accLo_q);
                    hi_d = negR_q ? -accHi_q : accHi_q;
                end else begin
                    {hi_d, lo_d} = negQ_q ? prodNeg : {accHi_q, accLo_q};
                end
`else
                hi_d = accHi_q;
                lo_d = accLo_q;
`endif
            end
            DONE: begin
                state_d = accept ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d   = '0;
            isDiv_d = op[1];
            accHi_d = '0;
            accLo_d = aMag;
            opB_d   = bMag;
`ifdef MULT_DIV_SIGNED_EN
            negQ_d    = isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            negR_d    = isSigned && a[WIDTH-1];
            divZero_d = (b == '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            isDiv_q <= 1'b0;
            accHi_q <= '0;
            accLo_q <= '0;
            opB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_DIV_SIGNED_EN
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            divZero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isDiv_q <= isDiv_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            opB_q   <= opB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULT_DIV_SIGNED_EN
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            divZero_q <= divZero_d;
`endif
        end
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic/latency reference model compared every cycle,
// plus directed vectors with hand-computed results (honours MULT_DIV_SIGNED_EN).
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [2*W-1:0] modelResult(input logic [1:0] mop,
                                                   input logic [W-1:0] ma,
                                                   input logic [W-1:0] mb);
        longint       sa, sb;
        logic         sgn;
        logic [W-1:0] q, r;
`ifdef MULT_DIV_SIGNED_EN
        sgn = mop[0];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(ma)) : longint'({32'b0, ma});
        sb = sgn ? longint'($signed(mb)) : longint'({32'b0, mb});
        if (!mop[1]) return 64'(sa * sb);
        if (mb == '0) return {ma, {W{1'b1}}};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {r, q};
    endfunction

    // Timing model: an accepted op completes 34 cycles later; reset wipes everything.
    int             mCnt = 0;
    logic           mDone = 1'b0;
    logic           mValid = 1'b0;
    logic [2*W-1:0] mPending = '0;
    logic [2*W-1:0] mOut = '0;

    always @(posedge clk) begin
        if (!clear_n) begin
            mCnt   <= 0;
            mDone  <= 1'b0;
            mOut   <= '0;
            mValid <= 1'b1;
        end else if (start && mCnt == 0) begin
            mPending <= modelResult(op, a, b);
            mCnt     <= 33;
            mDone    <= 1'b0;
        end else if (mCnt > 0) begin
            mCnt  <= mCnt - 1;
            mDone <= (mCnt == 1);
            if (mCnt == 1) mOut <= mPending;
        end else begin
            mDone <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model busy", 64'(busy), 64'(mCnt > 0));
            checkOutput("model done", 64'(done), 64'(mDone));
            checkOutput("model hilo", {hi, lo}, mOut);
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
        int n;
        applyStimulus(o, x, y);
        waitDone(1, n);
        checkOutput({name, " latency"}, 64'(n), 64'd34);
        checkOutput({name, " hi"}, 64'(hi), 64'(eHi));
        checkOutput({name, " lo"}, 64'(lo), 64'(eLo));
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, n2, sawDone;
        vecs[0] = '{"multu max*2",   2'b00, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
`ifdef MULT_DIV_SIGNED_EN
        vecs[1] = '{"mult -3*7",     2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{"div -7/2",      2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"div min/-1",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{"div 7/-2",      2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
`else
        vecs[1] = '{"mult -3*7",     2'b01, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB};
        vecs[2] = '{"div -7/2",      2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[4] = '{"div min/-1",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[7] = '{"div 7/-2",      2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000};
`endif
        vecs[3] = '{"divu 100/0",    2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5] = '{"div -7/0",      2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{"mult min*min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        clear_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hilo", {hi, lo}, 64'd0);
        clear_n = 1'b1;

        foreach (vecs[i]) runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Mid-operation reset: previous hi/lo are nonzero, so clearing is observable.
        applyStimulus(2'b10, 32'd100, 32'd7);
        repeat (8) begin @(posedge clk); #1; end
        clear_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset hilo", {hi, lo}, 64'd0);
        clear_n = 1'b1;
        sawDone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) sawDone = 1;
        end
        checkOutput("midreset no done", 64'(sawDone), 64'd0);
        runOp("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        // A start pulse while busy must be dropped, and operand changes ignored.
        applyStimulus(2'b00, 32'd3, 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("ignored start busy", 64'(busy), 64'd1);
        waitDone(6, n);
        checkOutput("ignored start latency", 64'(n), 64'd34);
        checkOutput("ignored start hi", 64'(hi), 64'd0);
        checkOutput("ignored start lo", 64'(lo), 64'd15);

        // Start held high: second op accepted in DONE with the operands present then.
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        a = 32'd6;
        waitDone(1, n);
        checkOutput("b2b first latency", 64'(n), 64'd34);
        checkOutput("b2b first lo", 64'(lo), 64'd15);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("b2b busy after done", 64'(busy), 64'd1);
        checkOutput("b2b done dropped", 64'(done), 64'd0);
        waitDone(1, n2);
        checkOutput("b2b second latency", 64'(n2), 64'd34);
        checkOutput("b2b second hi", 64'(hi), 64'd0);
        checkOutput("b2b second lo", 64'(lo), 64'd30);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
